// File: rtl/tracklet_product_rescale.sv
// Rescales signed multiplier products to working precision: round half-up, arithmetic shift, saturate.
// Two-cycle latency, one item per cycle; a stalled output holds both stages and drops in_ready when full.
module tracklet_product_rescale #(
  parameter int IN_W  = 34,
  parameter int OUT_W = 18,
  parameter int SHIFT = 14,
  parameter int TAG_W = 7
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_product,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf,
  input  logic             ovf_clear,
  output logic [15:0]      ovf_count
);

  localparam int SUM_W = IN_W + 1;
  localparam logic [SUM_W-1:0] RND     = {{(SUM_W-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic             s1_valid;
  logic [SUM_W-1:0] s1_sum;
  logic [TAG_W-1:0] s1_tag;
  logic             adv1;
  logic             adv2;
  logic [SUM_W-1:0] sum_d;
  logic [SUM_W-1:0] q;
  logic [SUM_W-OUT_W:0] q_hi;
  logic             q_ovf;
  logic [OUT_W-1:0] q_sat;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  // One extra bit of headroom so adding the rounding constant never wraps.
  assign sum_d = {in_product[IN_W-1], in_product} + RND;
  assign q     = $signed(s1_sum) >>> SHIFT;

  // The result fits only if every bit above the output sign bit matches it.
  assign q_hi  = q[SUM_W-1:OUT_W-1];
  assign q_ovf = !((&q_hi) || !(|q_hi));
  assign q_sat = q_ovf ? (q[SUM_W-1] ? OUT_MIN : OUT_MAX) : q[OUT_W-1:0];

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s1_tag    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sum <= sum_d;
          s1_tag <= in_tag;
        end
      end
      if (adv2) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= q_sat;
          out_tag  <= s1_tag;
          out_ovf  <= q_ovf;
        end
      end
    end
  end

  // Clear wins over a coincident increment; the count sticks at all-ones.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      ovf_count <= '0;
    end else if (ovf_clear) begin
      ovf_count <= '0;
    end else if (out_valid && out_ready && out_ovf && (ovf_count != 16'hFFFF)) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_tracklet_product_rescale.sv
// Randomized and directed bench for tracklet_product_rescale against an arithmetic reference model.
module tb_tracklet_product_rescale;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] in_product;
  logic [6:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_data;
  logic [6:0]  out_tag;
  logic        out_ovf;
  logic        ovf_clear;
  logic [15:0] ovf_count;

  tracklet_product_rescale dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_ovf    (out_ovf),
    .ovf_clear  (ovf_clear),
    .ovf_count  (ovf_count)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [17:0] d;
    logic [6:0]  t;
    logic        o;
    int          a;
  } item_t;

  item_t       q[$];
  logic [15:0] mcnt;
  int          stepno;
  bit          prev_rst;
  int          n_tests;
  int          n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (step %0d)", tag, got, exp, stepno);
    end
  endtask

  // Reference: floor((p + 2^13) / 2^14) via integer division, then clamp to 18-bit signed.
  function automatic item_t ref_item(input logic [33:0] prod, input logic [6:0] tg, input int stp);
    item_t  it;
    longint p;
    longint num;
    longint qq;
    p   = longint'($signed(prod));
    num = p + 64'sd8192;
    qq  = num / 64'sd16384;
    if ((num % 64'sd16384) != 0 && num < 0) qq = qq - 1;
    if (qq > 64'sd131071) begin
      it.d = 18'h1FFFF; it.o = 1'b1;
    end else if (qq < -64'sd131072) begin
      it.d = 18'h20000; it.o = 1'b1;
    end else begin
      it.d = qq[17:0];  it.o = 1'b0;
    end
    it.t = tg;
    it.a = stp;
    return it;
  endfunction

  // One clock: drive at negedge, check outputs against the model, then advance the model past the posedge.
  // An item accepted in step n is visible on the output from step n+2 until delivered.
  task automatic step(input bit rn, input bit iv, input logic [33:0] prod, input logic [6:0] tg,
                      input bit ordy, input bit clr, output bit acc);
    bit    exp_ov;
    bit    exp_irdy;
    item_t it;
    @(negedge ap_clk);
    ap_rst_n   = rn;
    in_valid   = iv;
    in_product = prod;
    in_tag     = tg;
    out_ready  = ordy;
    ovf_clear  = clr;
    #1;
    exp_ov = 1'b0;
    if (q.size() > 0) exp_ov = (stepno - q[0].a) >= 2;
    exp_irdy = !(q.size() >= 2 && !ordy);
    chk("in_ready", in_ready, exp_irdy);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      chk("out_data", out_data, q[0].d);
      chk("out_tag", out_tag, q[0].t);
      chk("out_ovf", out_ovf, q[0].o);
    end
    chk("ovf_count", ovf_count, mcnt);
    if (prev_rst) begin
      chk("rst_data", out_data, 0);
      chk("rst_tag", out_tag, 0);
      chk("rst_ovf", out_ovf, 0);
    end
    acc = 1'b0;
    if (!rn) begin
      q.delete();
      mcnt = '0;
    end else begin
      if (exp_ov && ordy) begin
        it = q.pop_front();
        if (!clr && it.o && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      end
      if (clr) mcnt = '0;
      if (iv && exp_irdy) begin
        acc = 1'b1;
        q.push_back(ref_item(prod, tg, stepno));
      end
    end
    prev_rst = !rn;
    stepno++;
  endtask

  task automatic idle(input int n, input bit ordy);
    bit a;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, ordy, 1'b0, a);
  endtask

  task automatic send(input logic [33:0] prod, input logic [6:0] tg);
    bit a;
    a = 1'b0;
    for (int i = 0; i < 20 && !a; i++) step(1'b1, 1'b1, prod, tg, 1'b1, 1'b0, a);
    chk("send_timeout", a, 1);
  endtask

  function automatic logic [33:0] rand_prod();
    logic [63:0] r;
    longint      v;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 3))
      0: v = longint'($signed(r[33:0]));
      1: v = longint'($signed(r[17:0]));
      2: v = (longint'($urandom_range(0, 2000)) - 1000) * 16384 + 8192 + longint'($urandom_range(0, 2)) - 1;
      default: begin
        if (r[40]) v = 64'sd2147475456 + longint'($urandom_range(0, 32)) - 16;
        else       v = -64'sd2147491840 + longint'($urandom_range(0, 32)) - 16;
      end
    endcase
    return v[33:0];
  endfunction

  logic [33:0] t1_prod [5];
  logic [33:0] t4_prod;

  initial begin
    bit a;
    int idx;
    n_tests = 0; n_fail = 0; stepno = 0; prev_rst = 1'b0; mcnt = '0;
    ap_rst_n = 1'b0; in_valid = 1'b0; in_product = '0; in_tag = '0; out_ready = 1'b0; ovf_clear = 1'b0;
    t1_prod[0] = 34'd8191;
    t1_prod[1] = 34'd8192;
    t1_prod[2] = 34'd16384;
    t1_prod[3] = -34'sd8192;
    t1_prod[4] = -34'sd8193;

    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, a);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, a);
    idle(2, 1'b1);

    // Rounding around the half-LSB points, then both saturation directions.
    for (int i = 0; i < 5; i++) send(t1_prod[i], 7'(i + 1));
    send(34'sd2147483648, 7'd10);
    send(-34'sd8589934592, 7'd11);
    idle(3, 1'b1);
    chk("t2_count", ovf_count, 2);

    // Back-to-back stream with out_ready held high.
    for (int i = 0; i < 10; i++) send(34'(i * 20000 - 90000), 7'(20 + i));
    idle(3, 1'b1);

    // Output stall for five cycles in the middle of a stream.
    idx = 0;
    for (int s = 0; s < 40 && idx < 12; s++) begin
      t4_prod = 34'(idx * 37000 - 200000);
      step(1'b1, 1'b1, t4_prod, 7'(40 + idx), !(s >= 3 && s < 8), 1'b0, a);
      if (a) idx++;
    end
    chk("t4_all_sent", idx, 12);
    idle(3, 1'b1);

    // Clear coincident with the fourth saturated delivery.
    for (int i = 0; i < 8; i++)
      step(1'b1, i < 4, 34'sd2147483648, 7'(60 + i), 1'b1, i == 5, a);
    chk("t5_clear", ovf_count, 0);

    // Drive the counter into saturation.
    for (int i = 0; i < 65540; i++) step(1'b1, 1'b1, -34'sd8589934592, 7'(i), 1'b1, 1'b0, a);
    idle(3, 1'b1);
    chk("t5_sat", ovf_count, 16'hFFFF);

    // Reset with two items held in flight.
    step(1'b1, 1'b1, 34'sd2147483648, 7'd100, 1'b0, 1'b0, a);
    step(1'b1, 1'b1, 34'sd123456, 7'd101, 1'b0, 1'b0, a);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, a);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, a);
    step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, a);
    chk("t6_valid", out_valid, 0);
    chk("t6_count", ovf_count, 0);
    idle(4, 1'b1);

    for (int i = 0; i < 3000; i++)
      step(1'b1, $urandom_range(0, 3) != 0, rand_prod(), 7'($urandom_range(0, 127)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, a);
    idle(5, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
